// File: rtl/branch_target_buffer_pkg.sv
// Shared branch predictor definitions: 2-bit counter encodings, default table geometry,
// and PC index/tag slicing helpers that the IF-stage predict logic also uses.
package branch_target_buffer_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  localparam int unsigned DefEntries = 16;
  localparam int unsigned DefIdxW    = 4;
  localparam int unsigned DefTagW    = 32 - 2 - DefIdxW;

  // Word-aligned PC: bits [1:0] never take part in index or tag.
  function automatic logic [DefIdxW-1:0] pc_index(input logic [31:0] pc);
    return pc[DefIdxW+1:2];
  endfunction

  function automatic logic [DefTagW-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:DefIdxW+2];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state for a 2-bit saturating branch direction counter.
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_next_o
);

  always_comb begin
    ctr_next_o = ctr_i;
    unique case (ctr_i)
      CtrSnt: ctr_next_o = taken_i ? CtrWnt : CtrSnt;
      CtrWnt: ctr_next_o = taken_i ? CtrWt  : CtrSnt;
      CtrWt:  ctr_next_o = taken_i ? CtrSt  : CtrWnt;
      CtrSt:  ctr_next_o = taken_i ? CtrSt  : CtrWt;
      default: ctr_next_o = CtrWnt;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency lookup for IF, trained by MEM-stage branch resolution,
// plus a saturating mispredict counter for performance monitoring.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned ENTRIES = DefEntries,
  parameter int unsigned IDX_W   = DefIdxW,
  parameter int unsigned TAG_W   = 32 - 2 - IDX_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;

  logic        wr_en;
  logic [31:0] wr_target;
  ctr_e        wr_ctr, ctr_next;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = if_pc[IDX_W+1:2];
  assign lk_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is seen one cycle later.
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = !reset && lk_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? target_q[lk_idx] : 32'h0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter2 u_sat_counter2 (
    .ctr_i      (ctr_q[upd_idx]),
    .taken_i    (upd_taken),
    .ctr_next_o (ctr_next)
  );

  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[upd_idx];
    wr_ctr    = ctr_next;
    if (upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) wr_target = upd_target;
      end else if (upd_taken) begin
        // Taken miss replaces whatever lives at this index; not-taken misses never allocate.
        wr_en     = 1'b1;
        wr_target = upd_target;
        wr_ctr    = CtrWt;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid && upd_mispredict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CtrWnt;
      end
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= wr_target;
        ctr_q[upd_idx]    <= wr_ctr;
      end
    end
  end

  assign mispredict_cnt = cnt_q;

endmodule
